// File: rtl/prime_sequence_generator_if.sv
// Output stream of the prime generator: valid/ready handshake carrying one prime value.
// The master drives out_valid/out_prime and the slave drives out_ready.
interface prime_sequence_generator_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_prime;

    modport master (output out_valid, output out_prime, input out_ready);
    modport slave  (input out_valid, input out_prime, output out_ready);
endinterface

// File: rtl/prime_sequence_generator.sv
// Prime sequence generator: sweeps candidates 2..2^WIDTH-1 in ascending order, tests each by
// trial division using repeated subtraction, and emits every prime on a valid/ready stream.
// Optional feature macro: PRIME_COUNT_EN adds the prime_count port (handshakes since start).
module prime_sequence_generator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    prime_sequence_generator_if.master out_if,
    output logic                       busy,
    output logic                       done
`ifdef PRIME_COUNT_EN
    ,
    output logic [WIDTH-1:0]           prime_count
`endif
);
    localparam logic [WIDTH-1:0] CandMax   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CandFirst = WIDTH'(2);

    typedef enum logic [2:0] {StIdle, StLoad, StTest, StMod, StEmit, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   cand_q, cand_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    // Set by an accepted start so the next LOAD begins the sweep at 2 instead of cand+1.
    logic               restart_q, restart_d;
    logic [2*WIDTH-1:0] div_sq;
    logic               start_ok;
    logic               handshake;
    logic               last_cand;
    logic               out_valid;
    logic [WIDTH-1:0]   out_prime;

    assign start_ok  = start && ((state_q == StIdle) || (state_q == StDone));
    assign handshake = (state_q == StEmit) && out_if.out_ready;
    assign last_cand = (cand_q == CandMax);
    // Full double-width square so the div*div > cand test can never overflow.
    assign div_sq    = (2*WIDTH)'(div_q) * (2*WIDTH)'(div_q);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StLoad;
            StLoad:         state_d = StTest;
            StTest:         state_d = (div_sq > (2*WIDTH)'(cand_q)) ? StEmit : StMod;
            StMod: begin
                if (rem_q >= div_q) begin
                    state_d = StMod;
                end else if (rem_q == '0) begin
                    state_d = last_cand ? StDone : StLoad;
                end else begin
                    state_d = StTest;
                end
            end
            StEmit:         if (handshake) state_d = last_cand ? StDone : StLoad;
            default:        state_d = StIdle;
        endcase
    end

    // Datapath registers: candidate, divisor, running remainder.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand_q    <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            restart_q <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            restart_q <= restart_d;
        end
    end

    // Datapath next-state: one subtraction per MOD cycle, divisor bump on a nonzero remainder.
    always_comb begin
        cand_d    = cand_q;
        div_d     = div_q;
        rem_d     = rem_q;
        restart_d = restart_q;
        if (start_ok) restart_d = 1'b1;
        case (state_q)
            StLoad: begin
                cand_d    = restart_q ? CandFirst : cand_q + WIDTH'(1);
                div_d     = WIDTH'(2);
                rem_d     = cand_d;
                restart_d = 1'b0;
            end
            StTest: rem_d = cand_q;
            StMod: begin
                if (rem_q >= div_q) begin
                    rem_d = rem_q - div_q;
                end else if (rem_q != '0) begin
                    div_d = div_q + WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

`ifdef PRIME_COUNT_EN
    logic [WIDTH-1:0] count_q, count_d;

    // Accepted-prime counter: cleared by an accepted start, held once the sweep is done.
    always_comb begin
        count_d = count_q;
        if (start_ok) begin
            count_d = '0;
        end else if (handshake) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign prime_count = count_q;
`endif

    // Moore outputs decoded from the current state.
    always_comb begin
        out_valid = (state_q == StEmit);
        out_prime = out_valid ? cand_q : '0;
        busy      = (state_q == StLoad) || (state_q == StTest) ||
                    (state_q == StMod)  || (state_q == StEmit);
        done      = (state_q == StDone);
    end

    assign out_if.out_valid = out_valid;
    assign out_if.out_prime = out_prime;
endmodule

// File: tb/tb_prime_sequence_generator.sv
// Bench for prime_sequence_generator: a WIDTH=8 and a WIDTH=4 instance share clock and reset.
// Expected primes come from a modulo-based reference model and are queued when a sweep or
// vector is started, then popped at each accepted handshake.
module tb_prime_sequence_generator;
    localparam int unsigned WaitMax = 4000;

    typedef struct {
        int unsigned gap;    // cycles out_ready is held low after out_valid appears
        bit          glitch; // pulse start while busy before waiting for this prime
        logic [7:0]  prime;  // expected accepted value
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start8 = 1'b0;
    logic start4 = 1'b0;
    logic busy8, done8, busy4, done4;
`ifdef PRIME_COUNT_EN
    logic [7:0] cnt8;
    logic [3:0] cnt4;
`endif

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [15:0] exp_q[$];

    prime_sequence_generator_if #(.WIDTH(8)) if8 ();
    prime_sequence_generator_if #(.WIDTH(4)) if4 ();

    prime_sequence_generator #(.WIDTH(8)) dut8 (
        .clock (clk),
        .reset (rst),
        .start (start8),
        .out_if(if8),
        .busy  (busy8),
        .done  (done8)
`ifdef PRIME_COUNT_EN
        ,
        .prime_count(cnt8)
`endif
    );

    prime_sequence_generator #(.WIDTH(4)) dut4 (
        .clock (clk),
        .reset (rst),
        .start (start4),
        .out_if(if4),
        .busy  (busy4),
        .done  (done4)
`ifdef PRIME_COUNT_EN
        ,
        .prime_count(cnt4)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit w4);
        if (w4) start4 = 1'b1;
        else start8 = 1'b1;
        step();
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    function automatic bit is_prime_ref(input int unsigned v);
        if (v < 2) return 1'b0;
        for (int unsigned d = 2; d * d <= v; d++) begin
            if (v % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic cur_valid(input bit w4);
        return w4 ? if4.out_valid : if8.out_valid;
    endfunction

    function automatic logic [7:0] cur_prime(input bit w4);
        return w4 ? {4'b0, if4.out_prime} : if8.out_prime;
    endfunction

    function automatic logic cur_done(input bit w4);
        return w4 ? done4 : done8;
    endfunction

    task automatic set_ready(input bit w4, input logic v);
        if (w4) if4.out_ready = v;
        else if8.out_ready = v;
    endtask

    // Wait (bounded) for out_valid, optionally stall, then take one value and check it
    // against the head of the scoreboard queue.
    task automatic accept(input bit w4, input string name, input int unsigned gap,
                          input bit glitch, input logic [7:0] hold_exp,
                          output int unsigned lat, output bit ok);
        logic [7:0] got;
        logic [15:0] exp;
        ok  = 1'b0;
        lat = 0;
        set_ready(w4, 1'b0);
        if (glitch) begin
            pulse(w4);
            lat++;
        end
        while (!cur_valid(w4) && !cur_done(w4) && lat < WaitMax) begin
            step();
            lat++;
        end
        if (cur_valid(w4) !== 1'b1) begin
            chk({name, "_no_valid"}, 32'd0, 32'd1);
            return;
        end
        for (int unsigned i = 0; i < gap; i++) step();
        if (gap != 0) begin
            chk({name, "_hold_valid"}, cur_valid(w4), 1);
            chk({name, "_hold_prime"}, cur_prime(w4), hold_exp);
        end
        set_ready(w4, 1'b1);
        got = cur_prime(w4);
        step();
        set_ready(w4, 1'b0);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hffff;
        chk({name, "_prime"}, got, exp);
        chk({name, "_valid_drop"}, cur_valid(w4), 0);
        ok = 1'b1;
    endtask

    task automatic wait_done(input bit w4);
        int unsigned n = 0;
        while (!cur_done(w4) && n < WaitMax) begin
            step();
            n++;
        end
    endtask

    initial begin
        vec_t vec[8];
        int unsigned lat;
        int unsigned n_acc;
        bit ok;
        bit alive;

        vec[0] = '{gap: 20, glitch: 1'b0, prime: 8'd2};
        vec[1] = '{gap: 0,  glitch: 1'b1, prime: 8'd3};
        vec[2] = '{gap: 0,  glitch: 1'b0, prime: 8'd5};
        vec[3] = '{gap: 3,  glitch: 1'b1, prime: 8'd7};
        vec[4] = '{gap: 1,  glitch: 1'b0, prime: 8'd11};
        vec[5] = '{gap: 0,  glitch: 1'b1, prime: 8'd13};
        vec[6] = '{gap: 5,  glitch: 1'b0, prime: 8'd17};
        vec[7] = '{gap: 0,  glitch: 1'b1, prime: 8'd19};

        if8.out_ready = 1'b0;
        if4.out_ready = 1'b0;

        // Reset held from time zero, sampled and released between clock edges.
        #23;
        chk("rst_valid", if8.out_valid, 0);
        chk("rst_prime", if8.out_prime, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
`ifdef PRIME_COUNT_EN
        chk("rst_count", cnt8, 0);
`endif
        #10 rst = 1'b0;
        step();
        step();
        chk("idle_busy", busy8, 0);
        chk("idle_valid", if8.out_valid, 0);

        // Take 2,3,5 then reset while 7 is pending on the stream.
        pulse(1'b0);
        exp_q.push_back(16'd2);
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd5);
        for (int k = 0; k < 3; k++) accept(1'b0, "pre_rst", 0, 1'b0, 8'd0, lat, ok);
        lat = 0;
        while (!if8.out_valid && lat < WaitMax) begin
            step();
            lat++;
        end
        chk("pend_valid", if8.out_valid, 1);
        chk("pend_prime", if8.out_prime, 7);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", if8.out_valid, 0);
        chk("mid_rst_prime", if8.out_prime, 0);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_done", done8, 0);
`ifdef PRIME_COUNT_EN
        chk("mid_rst_count", cnt8, 0);
`endif
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("post_rst_busy", busy8, 0);
        chk("post_rst_valid", if8.out_valid, 0);

        // Full WIDTH=8 sweep: table vectors first, then the model for the remainder.
        pulse(1'b0);
        chk("busy_after_start", busy8, 1);
        n_acc = 0;
        alive = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (alive) begin
                exp_q.push_back(16'(vec[i].prime));
                accept(1'b0, "table", vec[i].gap, vec[i].glitch, vec[i].prime, lat, ok);
                if (ok) n_acc++;
                else alive = 1'b0;
                if (i == 0) chk("first_latency_le3", 32'(lat <= 3), 1);
            end
        end
        for (int unsigned v = 20; v < 256; v++) begin
            if (alive && is_prime_ref(v)) begin
                exp_q.push_back(16'(v));
                accept(1'b0, "sweep8", 0, 1'b0, 8'd0, lat, ok);
                if (ok) n_acc++;
                else alive = 1'b0;
            end
        end
        wait_done(1'b0);
        chk("w8_done", done8, 1);
        chk("w8_busy_at_done", busy8, 0);
        chk("w8_valid_at_done", if8.out_valid, 0);
        chk("w8_accepted", n_acc, 54);
`ifdef PRIME_COUNT_EN
        chk("w8_count", cnt8, 54);
`endif

        // Restart from DONE.
        pulse(1'b0);
        chk("w8_restart_done_low", done8, 0);
        chk("w8_restart_busy", busy8, 1);
        exp_q.push_back(16'd2);
        accept(1'b0, "w8_restart", 0, 1'b0, 8'd0, lat, ok);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();

        // WIDTH=4: two sweeps, the second started from DONE.
        for (int rep = 0; rep < 2; rep++) begin
            pulse(1'b1);
            if (rep == 1) chk("w4_restart_done_low", done4, 0);
            for (int unsigned v = 0; v < 16; v++) begin
                if (is_prime_ref(v)) exp_q.push_back(16'(v));
            end
            n_acc = 0;
            alive = 1'b1;
            while (alive && exp_q.size() != 0) begin
                accept(1'b1, "sweep4", 0, 1'b0, 8'd0, lat, ok);
                if (ok) n_acc++;
                else alive = 1'b0;
            end
            exp_q.delete();
            wait_done(1'b1);
            chk("w4_done", done4, 1);
            chk("w4_busy_at_done", busy4, 0);
            chk("w4_accepted", n_acc, 6);
`ifdef PRIME_COUNT_EN
            chk("w4_count", cnt4, 6);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
